// File: rtl/game_pkg.sv
// Shared types and constants for the two-player shooter game-flow logic.
package game_pkg;

  localparam int unsigned SCORE_W = 8;
  localparam int unsigned TIMER_W = 10;

  // State codes are visible on the state output, so the encoding is fixed.
  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StCountdown = 3'd1,
    StPlay      = 3'd2,
    StHitPause  = 3'd3,
    StGameOver  = 3'd4
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Loadable down-counter clocked by the frame clock; stops at zero.
module frame_timer
  import game_pkg::*;
#(
  parameter int unsigned Width = TIMER_W
) (
  input  logic             frame_clk,
  input  logic             Reset,
  input  logic             load,
  input  logic [Width-1:0] load_value,
  input  logic             enable,
  output logic [Width-1:0] count,
  output logic             zero
);

  logic [Width-1:0] count_q;

  // Load wins over counting; counting never wraps below zero.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (enable && (count_q != '0)) begin
      count_q <= count_q - Width'(1);
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/round_controller.sv
// Game-flow sequencer: scoring, round pacing, armor cooldown and bullet-clear pulses.
module round_controller
  import game_pkg::*;
#(
  parameter int unsigned WIN_SCORE        = 5,
  parameter int unsigned COUNTDOWN_FRAMES = 180,
  parameter int unsigned HIT_PAUSE_FRAMES = 60,
  parameter int unsigned ARMOR_COOLDOWN   = 300
) (
  input  logic               frame_clk,
  input  logic               Reset,
  input  logic               start,
  input  logic               player_1_hit,
  input  logic               player_2_hit,
  input  logic               armor_hit,
  input  logic               bullet_on_bullet_hit,
  output logic [2:0]         state,
  output logic               freeze,
  output logic               bullet_clear,
  output logic               armor_enable,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic [1:0]         winner,
  output logic [TIMER_W-1:0] countdown
);

  // Previous-frame copies of the level inputs.
  logic start_q, p1_hit_q, p2_hit_q, armor_hit_q, bob_hit_q;
  logic start_rise, p1_hit_rise, p2_hit_rise, armor_hit_rise, bob_hit_rise;

  state_t             state_q, state_d;
  logic [SCORE_W-1:0] p1_score_q, p1_score_d, p2_score_q, p2_score_d;
  logic [SCORE_W-1:0] p1_next, p2_next;
  logic [1:0]         winner_q, winner_d;
  logic               freeze_q, freeze_d;
  logic               bullet_clear_q, bullet_clear_d;
  logic               armor_en_q, armor_en_d;
  logic               p1_won, p2_won;

  // Round/pause timer and armor cooldown timer controls.
  logic               rt_load, rt_en, rt_zero;
  logic [TIMER_W-1:0] rt_value, rt_count;
  logic               at_load, at_en, at_zero;
  logic [TIMER_W-1:0] at_value, at_count;

  // Edge-detect history updates every frame regardless of state.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      start_q     <= 1'b0;
      p1_hit_q    <= 1'b0;
      p2_hit_q    <= 1'b0;
      armor_hit_q <= 1'b0;
      bob_hit_q   <= 1'b0;
    end else begin
      start_q     <= start;
      p1_hit_q    <= player_1_hit;
      p2_hit_q    <= player_2_hit;
      armor_hit_q <= armor_hit;
      bob_hit_q   <= bullet_on_bullet_hit;
    end
  end

  assign start_rise     = start & ~start_q;
  assign p1_hit_rise    = player_1_hit & ~p1_hit_q;
  assign p2_hit_rise    = player_2_hit & ~p2_hit_q;
  assign armor_hit_rise = armor_hit & ~armor_hit_q;
  assign bob_hit_rise   = bullet_on_bullet_hit & ~bob_hit_q;

  // Candidate scores if this frame's hits are taken; a hit on one player scores the other.
  always_comb begin
    p1_next = p2_hit_rise ? sat_inc(p1_score_q) : p1_score_q;
    p2_next = p1_hit_rise ? sat_inc(p2_score_q) : p2_score_q;
    p1_won  = (p1_next >= SCORE_W'(WIN_SCORE));
    p2_won  = (p2_next >= SCORE_W'(WIN_SCORE));
  end

  // Next-state, score, armor and timer control decode.
  always_comb begin
    state_d        = state_q;
    p1_score_d     = p1_score_q;
    p2_score_d     = p2_score_q;
    winner_d       = winner_q;
    bullet_clear_d = 1'b0;
    armor_en_d     = armor_en_q;
    rt_load        = 1'b0;
    rt_value       = '0;
    rt_en          = 1'b0;
    at_load        = 1'b0;
    at_value       = '0;
    at_en          = 1'b0;

    case (state_q)
      StIdle: begin
        armor_en_d = 1'b0;
        if (start_rise) begin
          state_d    = StCountdown;
          rt_load    = 1'b1;
          rt_value   = TIMER_W'(COUNTDOWN_FRAMES - 1);
          p1_score_d = '0;
          p2_score_d = '0;
          winner_d   = WIN_NONE;
        end
      end

      StCountdown: begin
        if (rt_zero) begin
          state_d    = StPlay;
          armor_en_d = 1'b1;
          at_load    = 1'b1;
          at_value   = '0;
        end else begin
          rt_en = 1'b1;
        end
      end

      StPlay: begin
        // Cooldown only advances during live play.
        at_en = (at_count != '0);
        if (at_zero && !armor_en_q) begin
          armor_en_d = 1'b1;
        end

        if (p1_hit_rise || p2_hit_rise) begin
          bullet_clear_d = 1'b1;
          p1_score_d     = p1_next;
          p2_score_d     = p2_next;
          if (p1_won || p2_won) begin
            state_d    = StGameOver;
            armor_en_d = 1'b0;
            if (p1_won && p2_won) begin
              winner_d = WIN_DRAW;
            end else if (p1_won) begin
              winner_d = WIN_P1;
            end else begin
              winner_d = WIN_P2;
            end
          end else begin
            state_d  = StHitPause;
            rt_load  = 1'b1;
            rt_value = TIMER_W'(HIT_PAUSE_FRAMES - 1);
          end
        end else if (armor_hit_rise && armor_en_q) begin
          bullet_clear_d = 1'b1;
          armor_en_d     = 1'b0;
          at_load        = 1'b1;
          at_value       = TIMER_W'(ARMOR_COOLDOWN - 1);
        end else if (bob_hit_rise) begin
          bullet_clear_d = 1'b1;
        end
      end

      StHitPause: begin
        if (rt_zero) begin
          state_d = StPlay;
        end else begin
          rt_en = 1'b1;
        end
      end

      StGameOver: begin
        armor_en_d = 1'b0;
        if (start_rise) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d    = StIdle;
        armor_en_d = 1'b0;
      end
    endcase

    freeze_d = (state_d != StPlay);
  end

  // Game-flow state and registered outputs.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q        <= StIdle;
      p1_score_q     <= '0;
      p2_score_q     <= '0;
      winner_q       <= WIN_NONE;
      freeze_q       <= 1'b1;
      bullet_clear_q <= 1'b0;
      armor_en_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      p1_score_q     <= p1_score_d;
      p2_score_q     <= p2_score_d;
      winner_q       <= winner_d;
      freeze_q       <= freeze_d;
      bullet_clear_q <= bullet_clear_d;
      armor_en_q     <= armor_en_d;
    end
  end

  // Only loaded on entry to COUNTDOWN/HIT_PAUSE and always exits at zero,
  // so its count doubles as the countdown output.
  frame_timer #(
    .Width(TIMER_W)
  ) u_round_timer (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .load      (rt_load),
    .load_value(rt_value),
    .enable    (rt_en),
    .count     (rt_count),
    .zero      (rt_zero)
  );

  frame_timer #(
    .Width(TIMER_W)
  ) u_armor_timer (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .load      (at_load),
    .load_value(at_value),
    .enable    (at_en),
    .count     (at_count),
    .zero      (at_zero)
  );

  assign state        = state_q;
  assign freeze       = freeze_q;
  assign bullet_clear = bullet_clear_q;
  assign armor_enable = armor_en_q;
  assign p1_score     = p1_score_q;
  assign p2_score     = p2_score_q;
  assign winner       = winner_q;
  assign countdown    = rt_count;

endmodule

// File: tb/tb_round_controller.sv
// Self-checking bench for round_controller with default parameters.
module tb_round_controller;

  localparam int unsigned WinScore = 5;

  logic       frame_clk;
  logic       Reset;
  logic       start, player_1_hit, player_2_hit, armor_hit, bullet_on_bullet_hit;
  logic [2:0] state;
  logic       freeze, bullet_clear, armor_enable;
  logic [7:0] p1_score, p2_score;
  logic [1:0] winner;
  logic [9:0] countdown;

  int checks   = 0;
  int failures = 0;
  int exp_p1   = 0;
  int exp_p2   = 0;
  int plays    = 0;

  typedef struct {
    logic [7:0] p1;
    logic [7:0] p2;
    logic [2:0] st;
    logic       bc;
    logic       ae;
    logic [1:0] win;
  } exp_t;

  exp_t sb_q[$];

  round_controller #(
    .WIN_SCORE       (WinScore),
    .COUNTDOWN_FRAMES(180),
    .HIT_PAUSE_FRAMES(60),
    .ARMOR_COOLDOWN  (300)
  ) dut (
    .frame_clk           (frame_clk),
    .Reset               (Reset),
    .start               (start),
    .player_1_hit        (player_1_hit),
    .player_2_hit        (player_2_hit),
    .armor_hit           (armor_hit),
    .bullet_on_bullet_hit(bullet_on_bullet_hit),
    .state               (state),
    .freeze              (freeze),
    .bullet_clear        (bullet_clear),
    .armor_enable        (armor_enable),
    .p1_score            (p1_score),
    .p2_score            (p2_score),
    .winner              (winner),
    .countdown           (countdown)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic play_tick();
    tick();
    plays++;
  endtask

  // Pops one expected record and compares it with the DUT outputs.
  task automatic sb_check(input string name);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb_q.pop_front();
      if (p1_score !== e.p1 || p2_score !== e.p2 || state !== e.st || bullet_clear !== e.bc ||
          armor_enable !== e.ae || winner !== e.win) begin
        failures++;
        $display("FAIL %s: got p1=%0d p2=%0d st=%0d bc=%0b ae=%0b win=%0d, expected p1=%0d p2=%0d st=%0d bc=%0b ae=%0b win=%0d",
                 name, p1_score, p2_score, state, bullet_clear, armor_enable, winner,
                 e.p1, e.p2, e.st, e.bc, e.ae, e.win);
      end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    start = 1'b0; player_1_hit = 1'b0; player_2_hit = 1'b0;
    armor_hit = 1'b0; bullet_on_bullet_hit = 1'b0;
    #2;
    checks++;
    if (state !== 3'd0 || freeze !== 1'b1 || bullet_clear !== 1'b0 || armor_enable !== 1'b0 ||
        p1_score !== 8'd0 || p2_score !== 8'd0 || winner !== 2'd0 || countdown !== 10'd0) begin
      failures++;
      $display("FAIL reset_values: got st=%0d frz=%0b bc=%0b ae=%0b p1=%0d p2=%0d win=%0d cd=%0d",
               state, freeze, bullet_clear, armor_enable, p1_score, p2_score, winner, countdown);
    end
    tick();
    Reset = 1'b0;
    tick();
    checks++;
    if (state !== 3'd0 || freeze !== 1'b1) begin
      failures++;
      $display("FAIL idle_hold: got st=%0d frz=%0b expected st=0 frz=1", state, freeze);
    end
  endtask

  // Start rise from IDLE, then 180 countdown frames into PLAY.
  task automatic start_game();
    exp_p1 = 0;
    exp_p2 = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (state !== 3'd1 || countdown !== 10'd179 || freeze !== 1'b1 || p1_score !== 8'd0 ||
        p2_score !== 8'd0 || winner !== 2'd0) begin
      failures++;
      $display("FAIL countdown_entry: got st=%0d cd=%0d frz=%0b p1=%0d p2=%0d win=%0d expected st=1 cd=179 frz=1 p1=0 p2=0 win=0",
               state, countdown, freeze, p1_score, p2_score, winner);
    end
    repeat (179) tick();
    checks++;
    if (state !== 3'd1 || countdown !== 10'd0) begin
      failures++;
      $display("FAIL countdown_last: got st=%0d cd=%0d expected st=1 cd=0", state, countdown);
    end
    tick();
    checks++;
    if (state !== 3'd2 || armor_enable !== 1'b1 || freeze !== 1'b0 || countdown !== 10'd0) begin
      failures++;
      $display("FAIL play_entry: got st=%0d ae=%0b frz=%0b cd=%0d expected st=2 ae=1 frz=0 cd=0",
               state, armor_enable, freeze, countdown);
    end
  endtask

  // One scoring frame from PLAY; waits out the pause if the game continues.
  task automatic score_hit(input logic h1, input logic h2, input logic ae);
    exp_t e;
    logic over;
    if (h2) exp_p1++;
    if (h1) exp_p2++;
    over  = (exp_p1 >= WinScore) || (exp_p2 >= WinScore);
    e.p1  = 8'(exp_p1);
    e.p2  = 8'(exp_p2);
    e.st  = over ? 3'd4 : 3'd3;
    e.bc  = 1'b1;
    e.ae  = over ? 1'b0 : ae;
    e.win = over ? {exp_p2 >= WinScore, exp_p1 >= WinScore} : 2'b00;
    sb_q.push_back(e);
    player_1_hit = h1;
    player_2_hit = h2;
    tick();
    player_1_hit = 1'b0;
    player_2_hit = 1'b0;
    sb_check("score_hit");
    tick();
    checks++;
    if (bullet_clear !== 1'b0) begin
      failures++;
      $display("FAIL score_hit_bc_width: got bc=%0b expected 0", bullet_clear);
    end
    if (!over) begin
      repeat (58) tick();
      checks++;
      if (state !== 3'd3 || countdown !== 10'd0) begin
        failures++;
        $display("FAIL pause_last: got st=%0d cd=%0d expected st=3 cd=0", state, countdown);
      end
      tick();
      checks++;
      if (state !== 3'd2 || freeze !== 1'b0) begin
        failures++;
        $display("FAIL pause_exit: got st=%0d frz=%0b expected st=2 frz=0", state, freeze);
      end
    end
  endtask

  task automatic test_countdown();
    start_game();
  endtask

  task automatic test_hold_hit();
    exp_t e;
    e.p1 = 8'd1; e.p2 = 8'd0; e.st = 3'd3; e.bc = 1'b1; e.ae = 1'b1; e.win = 2'd0;
    sb_q.push_back(e);
    exp_p1 = 1;
    player_2_hit = 1'b1;
    tick();
    sb_check("hold_hit_first");
    tick();
    checks++;
    if (bullet_clear !== 1'b0 || p1_score !== 8'd1) begin
      failures++;
      $display("FAIL hold_hit_second: got bc=%0b p1=%0d expected bc=0 p1=1", bullet_clear, p1_score);
    end
    repeat (8) tick();
    checks++;
    if (p1_score !== 8'd1 || state !== 3'd3 || countdown !== 10'd50) begin
      failures++;
      $display("FAIL hold_hit_count: got p1=%0d st=%0d cd=%0d expected p1=1 st=3 cd=50",
               p1_score, state, countdown);
    end
    // Hits during the pause are ignored.
    player_2_hit = 1'b0;
    player_1_hit = 1'b1;
    tick();
    player_1_hit = 1'b0;
    tick();
    checks++;
    if (p2_score !== 8'd0 || state !== 3'd3 || countdown !== 10'd48 || bullet_clear !== 1'b0) begin
      failures++;
      $display("FAIL pause_ignores_hit: got p2=%0d st=%0d cd=%0d bc=%0b expected p2=0 st=3 cd=48 bc=0",
               p2_score, state, countdown, bullet_clear);
    end
    repeat (48) tick();
    checks++;
    if (state !== 3'd3 || countdown !== 10'd0) begin
      failures++;
      $display("FAIL hold_pause_last: got st=%0d cd=%0d expected st=3 cd=0", state, countdown);
    end
    tick();
    checks++;
    if (state !== 3'd2 || p1_score !== 8'd1 || p2_score !== 8'd0) begin
      failures++;
      $display("FAIL hold_pause_exit: got st=%0d p1=%0d p2=%0d expected st=2 p1=1 p2=0",
               state, p1_score, p2_score);
    end
  endtask

  task automatic test_armor();
    exp_t e;
    e.p1 = 8'd1; e.p2 = 8'd0; e.st = 3'd2; e.bc = 1'b1; e.ae = 1'b0; e.win = 2'd0;
    sb_q.push_back(e);
    armor_hit = 1'b1;
    tick();
    sb_check("armor_hit");
    plays = 0;
    play_tick();
    armor_hit = 1'b0;
    checks++;
    if (bullet_clear !== 1'b0) begin
      failures++;
      $display("FAIL armor_bc_width: got bc=%0b expected 0", bullet_clear);
    end
    play_tick();
    armor_hit = 1'b1;
    play_tick();
    armor_hit = 1'b0;
    checks++;
    if (armor_enable !== 1'b0 || bullet_clear !== 1'b0) begin
      failures++;
      $display("FAIL armor_second_ignored: got ae=%0b bc=%0b expected ae=0 bc=0",
               armor_enable, bullet_clear);
    end
    while (plays < 100) play_tick();
    // A pause in the middle of the cooldown must not consume cooldown frames.
    exp_p1 = 2;
    player_2_hit = 1'b1;
    play_tick();
    player_2_hit = 1'b0;
    checks++;
    if (state !== 3'd3 || p1_score !== 8'(exp_p1)) begin
      failures++;
      $display("FAIL armor_mid_hit: got st=%0d p1=%0d expected st=3 p1=%0d", state, p1_score, exp_p1);
    end
    repeat (60) tick();
    while (plays < 299) play_tick();
    checks++;
    if (armor_enable !== 1'b0 || state !== 3'd2) begin
      failures++;
      $display("FAIL armor_early: got ae=%0b st=%0d expected ae=0 st=2", armor_enable, state);
    end
    play_tick();
    checks++;
    if (armor_enable !== 1'b1) begin
      failures++;
      $display("FAIL armor_reenable: got ae=%0b expected 1", armor_enable);
    end
  endtask

  task automatic test_combo();
    armor_hit = 1'b1;
    bullet_on_bullet_hit = 1'b1;
    tick();
    armor_hit = 1'b0;
    bullet_on_bullet_hit = 1'b0;
    checks++;
    if (bullet_clear !== 1'b1 || armor_enable !== 1'b0 || state !== 3'd2 ||
        p1_score !== 8'd2 || p2_score !== 8'd0) begin
      failures++;
      $display("FAIL combo_armor: got bc=%0b ae=%0b st=%0d p1=%0d p2=%0d expected bc=1 ae=0 st=2 p1=2 p2=0",
               bullet_clear, armor_enable, state, p1_score, p2_score);
    end
    tick();
    checks++;
    if (bullet_clear !== 1'b0) begin
      failures++;
      $display("FAIL combo_single_pulse: got bc=%0b expected 0", bullet_clear);
    end
    bullet_on_bullet_hit = 1'b1;
    tick();
    bullet_on_bullet_hit = 1'b0;
    checks++;
    if (bullet_clear !== 1'b1 || state !== 3'd2 || armor_enable !== 1'b0) begin
      failures++;
      $display("FAIL bob_alone: got bc=%0b st=%0d ae=%0b expected bc=1 st=2 ae=0",
               bullet_clear, state, armor_enable);
    end
    tick();
    checks++;
    if (bullet_clear !== 1'b0) begin
      failures++;
      $display("FAIL bob_pulse_width: got bc=%0b expected 0", bullet_clear);
    end
  endtask

  // From 2:0 reach 4:4, then a simultaneous double hit ends in a draw.
  task automatic test_draw();
    score_hit(1'b1, 1'b1, 1'b0);
    score_hit(1'b1, 1'b1, 1'b0);
    score_hit(1'b1, 1'b0, 1'b0);
    score_hit(1'b1, 1'b0, 1'b0);
    score_hit(1'b1, 1'b1, 1'b0);
    checks++;
    if (state !== 3'd4 || freeze !== 1'b1 || armor_enable !== 1'b0 || countdown !== 10'd0 ||
        winner !== 2'b11) begin
      failures++;
      $display("FAIL game_over_outputs: got st=%0d frz=%0b ae=%0b cd=%0d win=%0d expected st=4 frz=1 ae=0 cd=0 win=3",
               state, freeze, armor_enable, countdown, winner);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (state !== 3'd0 || winner !== 2'b11 || p1_score !== 8'd5 || p2_score !== 8'd5) begin
      failures++;
      $display("FAIL draw_to_idle: got st=%0d win=%0d p1=%0d p2=%0d expected st=0 win=3 p1=5 p2=5",
               state, winner, p1_score, p2_score);
    end
    tick();
  endtask

  task automatic test_p1_win();
    start_game();
    for (int i = 0; i < 5; i++) score_hit(1'b0, 1'b1, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (state !== 3'd0 || winner !== 2'b01 || p1_score !== 8'd5 || p2_score !== 8'd0) begin
      failures++;
      $display("FAIL p1_win_idle: got st=%0d win=%0d p1=%0d p2=%0d expected st=0 win=1 p1=5 p2=0",
               state, winner, p1_score, p2_score);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    start_game();
    score_hit(1'b0, 1'b1, 1'b1);
    score_hit(1'b0, 1'b1, 1'b1);
    player_2_hit = 1'b1;
    tick();
    player_2_hit = 1'b0;
    checks++;
    if (state !== 3'd3 || p1_score !== 8'd3) begin
      failures++;
      $display("FAIL pre_reset: got st=%0d p1=%0d expected st=3 p1=3", state, p1_score);
    end
    repeat (10) tick();
    #2;
    Reset = 1'b1;
    #1;
    checks++;
    if (state !== 3'd0 || p1_score !== 8'd0 || p2_score !== 8'd0 || freeze !== 1'b1 ||
        armor_enable !== 1'b0 || countdown !== 10'd0 || bullet_clear !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: got st=%0d p1=%0d p2=%0d frz=%0b ae=%0b cd=%0d bc=%0b expected st=0 p1=0 p2=0 frz=1 ae=0 cd=0 bc=0",
               state, p1_score, p2_score, freeze, armor_enable, countdown, bullet_clear);
    end
    tick();
    Reset = 1'b0;
    tick();
    checks++;
    if (state !== 3'd0 || countdown !== 10'd0) begin
      failures++;
      $display("FAIL post_reset_idle: got st=%0d cd=%0d expected st=0 cd=0", state, countdown);
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_hold_hit();
    test_armor();
    test_combo();
    test_draw();
    test_p1_win();
    test_reset_mid();
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/round_controller.md
Name: round_controller

Overview:
- Game-flow sequencer for the two-player shooter.
- Consumes the hit flags from the bullet hit detector and owns score keeping, round pacing, armor enable and bullet-clear requests.
- Sits between the hit detector and the player/bullet/armor motion blocks, and runs on the frame clock.
- Drives freeze/clear controls back to the motion logic and score/winner values to the HUD.

Parameters:
- WIN_SCORE, 5: score that ends the game; valid range 1..255.
- COUNTDOWN_FRAMES, 180: frames of pre-round countdown; valid range 1..1023.
- HIT_PAUSE_FRAMES, 60: frames of freeze after a player hit; valid range 1..1023.
- ARMOR_COOLDOWN, 300: frames armor stays disabled after being hit; valid range 1..1023.

Ports:
- frame_clk  in  1  frame clock; only clock.
- Reset  in  1  asynchronous, active-high reset.
- start  in  1  start/restart button, level; rising edge used.
- player_1_hit  in  1  P1 struck (level, may persist several frames).
- player_2_hit  in  1  P2 struck (level).
- armor_hit  in  1  any bullet touching armor (level).
- bullet_on_bullet_hit  in  1  bullets collided (level).
- state  out  3  current FSM state code.
- freeze  out  1  motion blocks hold positions and ignore fire.
- bullet_clear  out  1  one-frame pulse; bullets return to owners.
- armor_enable  out  1  armor visible and collidable.
- p1_score  out  8  P1 points.
- p2_score  out  8  P2 points.
- winner  out  2  00 none, 01 P1, 10 P2, 11 draw.
- countdown  out  10  remaining frames of the active timer, 0 otherwise.

Behaviour:
- Clock, reset and registers:
  - Clock and reset: one clock, frame_clk; reset is asynchronous and active-high, named Reset.
  - All state updates on posedge frame_clk or posedge Reset.
  - All outputs are registered.
- Reset values:
  - state=IDLE, freeze=1, bullet_clear=0, armor_enable=0.
  - Scores 0, winner=00, countdown=0, timers 0.
  - Edge-detect registers 0.
- Reset mid-operation returns to the reset values immediately, whatever the state.
- Edge detection:
  - Each level input x yields x_rise = x & ~x_d.
  - x_d updates every frame in every state.
  - Only rises act, so a hit held N frames counts once.
- FSM states: IDLE(0), COUNTDOWN(1), PLAY(2), HIT_PAUSE(3), GAME_OVER(4).
- IDLE:
  - freeze=1, armor_enable=0.
  - On start_rise -> COUNTDOWN, timer=COUNTDOWN_FRAMES-1, scores=0, winner=00.
- COUNTDOWN:
  - freeze=1; timer decrements each frame.
  - When timer==0 -> PLAY, armor_enable=1, armor cooldown cleared.
- PLAY:
  - freeze=0; start is ignored.
  - Priority per frame: player hits > armor_hit > bullet_on_bullet_hit.
  - player_2_hit_rise increments p1_score; player_1_hit_rise increments p2_score. Both may occur in one frame, and both score.
  - Scores saturate at 255.
  - Any player hit: bullet_clear=1 next frame.
  - Any player hit, new score(s) reaching WIN_SCORE -> GAME_OVER, otherwise -> HIT_PAUSE with timer=HIT_PAUSE_FRAMES-1.
  - armor_hit_rise with armor_enable=1 (and no player hit): armor_enable=0, cooldown=ARMOR_COOLDOWN-1, bullet_clear pulse.
  - armor_hit while armor_enable=0 is ignored.
  - bullet_on_bullet_hit_rise alone: bullet_clear pulse, stay in PLAY.
- Armor cooldown:
  - Decrements only in PLAY.
  - On reaching 0 with armor_enable=0, armor_enable=1 on the following frame.
- HIT_PAUSE:
  - freeze=1; hits ignored; armor cooldown holds.
  - When timer==0 -> PLAY.
- GAME_OVER:
  - freeze=1, armor_enable=0.
  - winner=01 if only P1 reached WIN_SCORE, 10 if only P2, 11 if both reached it in the same frame.
  - Scores hold. On start_rise -> IDLE with winner held; winner clears on the next start.
- Latency:
  - A qualifying rise sampled at edge k gives score, state and bullet_clear visible after edge k.
  - bullet_clear lasts exactly one frame.
- countdown output mirrors the active timer in COUNTDOWN/HIT_PAUSE, and is 0 elsewhere.

Decomposition:
- Package game_pkg holds:
  - the state_t enum (3-bit) with the codes above;
  - winner codes WIN_NONE/WIN_P1/WIN_P2/WIN_DRAW;
  - SCORE_W=8 and TIMER_W=10.
- Sub-module frame_timer: loadable 10-bit down-counter with load, load_value, enable, count and zero outputs, and asynchronous Reset.
- Two frame_timer instances: the round/pause timer and the armor cooldown timer.

Test Plan:
- Reset, then start pulse -> state=1, countdown=179; after 180 frames state=2, armor_enable=1, freeze=0.
- In PLAY, hold player_2_hit high 10 frames -> p1_score=1 (not 10), one-frame bullet_clear, state=3; after 60 frames state=2.
- With p1_score=4 and p2_score=4, assert player_1_hit and player_2_hit in the same frame -> both scores 5, state=4, winner=11.
- armor_hit rise in PLAY -> armor_enable=0, bullet_clear pulse; a second armor_hit is ignored; after 300 PLAY frames armor_enable=1 (HIT_PAUSE frames do not count).
- bullet_on_bullet_hit rise together with armor_hit -> only the armor path acts: one bullet_clear pulse, armor_enable=0, scores unchanged.
- Assert Reset mid-HIT_PAUSE with p1_score=3 -> state=0, scores 0, freeze=1, armor_enable=0 immediately, without waiting for a clock edge.
